varlat_bank_arbiter: RTL and testbench
======================================

// Module: varlat_bank_arbiter
// PURPOSE
//  Shares one variable-latency memory bank among NumIn TCDM-style requesters.
//  Arbitration is round-robin, and the granted request stays locked while the bank stalls.
//  A FIFO of initiator indices returns responses in order to the initiator that issued them.
//  Sits between the in-order interconnect outputs and a bank, or in front of any single shared bank.
// PARAMETERS
//  NumIn          4              number of requesters (>=2)
//  AddrWidth      12             bank-local word address width
//  DataWidth      32             data word width
//  BeWidth        DataWidth/8    byte-enable width
//  NumOutstanding 2              max granted-but-unanswered requests (>=1)
// PORTS
//  clk_i     in   1                      clock
//  rst_i     in   1                      synchronous active-high reset
//  req_i     in   NumIn                  request per initiator; held until gnt_o
//  add_i     in   NumIn*AddrWidth        bank word address
//  we_i      in   NumIn                  1 store, 0 load
//  wdata_i   in   NumIn*DataWidth        write data
//  be_i      in   NumIn*BeWidth          byte enables
//  gnt_o     out  NumIn                  grant, one-hot or zero
//  vld_o     out  NumIn                  response valid (reads and writes)
//  rdata_o   out  NumIn*DataWidth        response data, broadcast to all initiators
//  req_o     out  1                      bank request
//  gnt_i     in   1                      bank grant
//  add_o/we_o/wdata_o/be_o  out          fields of the selected initiator
//  rvalid_i  in   1                      bank response valid
//  rready_o  out  1                      response ready
//  rdata_i   in   DataWidth              bank response data
//  outst_o   out  $clog2(NumOutstanding+1)  current outstanding count
// BEHAVIOUR
//  - State: rr_q (next-priority index), lock_q/lock_idx_q, idx FIFO (depth NumOutstanding, no fall-through).
//  - Reset (rst_i=1 at posedge): rr_q=0, lock_q=0, FIFO empty, outst_o=0.
//    Outputs follow combinationally: with req_i=0, all of req_o/gnt_o/vld_o/rready_o are 0.
//  - Selection: if lock_q, winner=lock_idx_q. Otherwise winner = first i with req_i[i],
//    searching from rr_q upward and wrapping modulo NumIn.
//  - req_o = |req_i & ~full.
//    add_o/we_o/wdata_o/be_o = winner fields; outputs are 0 when req_o=0.
//  - Handshake: hs = req_o & gnt_i. gnt_o[winner]=hs, all other bits 0. Zero-cycle grant (combinational on gnt_i).
//  - On hs:
//    - push winner into the FIFO;
//    - rr_q <= (winner==NumIn-1) ? 0 : winner+1;
//    - lock_q <= 0.
//  - On req_o & ~gnt_i: lock_q<=1 and lock_idx_q<=winner. The bank sees stable fields until granted.
//  - Defensive unlock: if lock_q and req_i[lock_idx_q]=0, clear the lock and re-arbitrate in the same cycle.
//  - FIFO full: req_o=0 and gnt_o=0. The lock persists and the pointer is unchanged.
//  - Response: rready_o = ~empty.
//    vld_o[head]=rvalid_i & ~empty, other bits 0. rdata_o = rdata_i for all initiators.
//    Pop on rvalid_i & rready_o.
//  - A response is never seen in the grant cycle (no fall-through); minimum latency is 1 cycle.
//  - Simultaneous push and pop: allowed when not full; count unchanged.
//    When full, a pop in cycle t frees the slot for a grant in t+1, not t.
//  - rvalid_i while empty: ignored, rready_o=0, no vld_o.
//  - outst_o = FIFO usage: +1 on push, -1 on pop, unchanged on both, saturates at NumOutstanding by construction.
//  - Reset mid-operation: all in-flight responses are dropped. The bank must be reset in the same cycle.
// TESTING
//  1. Reset, single initiator: req_i=4'b0010, add=0x05, gnt_i=1.
//     -> gnt_o=0010 in the same cycle, add_o=0x05.
//     With rvalid_i 2 cycles later -> vld_o=0010, outst_o goes 1 then 0.
//  2. Round-robin: req_i=4'b1111 held, gnt_i=1 every cycle, rvalid_i=1 every cycle, NumOutstanding=2.
//     -> grant order 0,1,2,3,0.
//  3. Stall lock: req_i=1111, gnt_i=0 for 3 cycles.
//     -> req_o=1 and winner 0 fields stable; assert req_i[2] change has no effect.
//     With gnt_i=1 -> gnt_o=0001, next winner 1.
//  4. Full: NumOutstanding=2, two grants with no rvalid_i -> req_o=0, gnt_o=0, outst_o=2.
//     With rvalid_i=1 one cycle -> vld_o to the first initiator. Next cycle req_o=1.
//  5. In-order return: grants to 3 then 1 -> first rvalid_i gives vld_o=1000, second gives 0010.
//     A spurious rvalid_i when empty -> no vld_o.
//  6. Reset with 2 outstanding -> outst_o=0, rready_o=0, rr_q=0, next grant goes to the lowest requester.

Source files
------------

// File: rtl/varlat_bank_arbiter_if.sv
// Initiator-side and bank-side bundle of the variable-latency bank arbiter.
// The slave modport is the arbiter view; master is the environment view.
interface varlat_bank_arbiter_if #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned AddrWidth      = 12,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned NumOutstanding = 2
);
    localparam int unsigned CntW = $clog2(NumOutstanding + 1);

    logic [NumIn-1:0]           req_i;
    logic [NumIn*AddrWidth-1:0] add_i;
    logic [NumIn-1:0]           we_i;
    logic [NumIn*DataWidth-1:0] wdata_i;
    logic [NumIn*BeWidth-1:0]   be_i;
    logic [NumIn-1:0]           gnt_o;
    logic [NumIn-1:0]           vld_o;
    logic [NumIn*DataWidth-1:0] rdata_o;

    logic                       req_o;
    logic                       gnt_i;
    logic [AddrWidth-1:0]       add_o;
    logic                       we_o;
    logic [DataWidth-1:0]       wdata_o;
    logic [BeWidth-1:0]         be_o;
    logic                       rvalid_i;
    logic                       rready_o;
    logic [DataWidth-1:0]       rdata_i;
    logic [CntW-1:0]            outst_o;

    modport slave (
        input  req_i, add_i, we_i, wdata_i, be_i,
        output gnt_o, vld_o, rdata_o,
        output req_o, add_o, we_o, wdata_o, be_o, rready_o, outst_o,
        input  gnt_i, rvalid_i, rdata_i
    );

    modport master (
        output req_i, add_i, we_i, wdata_i, be_i,
        input  gnt_o, vld_o, rdata_o,
        input  req_o, add_o, we_o, wdata_o, be_o, rready_o, outst_o,
        output gnt_i, rvalid_i, rdata_i
    );
endinterface

// File: rtl/varlat_bank_arbiter.sv
// Round-robin arbiter sharing one variable-latency bank among NumIn initiators.
// Stalled grants stay locked; an index FIFO routes responses back in order.
module varlat_bank_arbiter #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned AddrWidth      = 12,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned NumOutstanding = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    varlat_bank_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CntW = $clog2(NumOutstanding + 1);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] fifo_q [NumOutstanding];
    logic [IdxW-1:0] fifo_d [NumOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            full;
    logic            empty;
    logic            lock_hold;
    logic [IdxW-1:0] rr_win;
    logic [IdxW-1:0] winner;
    logic            req;
    logic            hs;
    logic            pop;
    int unsigned     cand;
    logic            found;

    assign full  = (cnt_q == CntW'(NumOutstanding));
    assign empty = (cnt_q == '0);

    // A lock whose initiator withdrew is ignored so arbitration proceeds this cycle.
    assign lock_hold = lock_q & bus.req_i[lock_idx_q];

    always_comb begin
        rr_win = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < int'(NumIn); k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                rr_win = IdxW'(cand);
            end
        end
    end

    assign winner = lock_hold ? lock_idx_q : rr_win;
    assign req    = (|bus.req_i) & ~full;
    assign hs     = req & bus.gnt_i;
    assign pop    = bus.rvalid_i & ~empty;

    always_comb begin
        bus.req_o   = req;
        bus.add_o   = '0;
        bus.we_o    = 1'b0;
        bus.wdata_o = '0;
        bus.be_o    = '0;
        bus.gnt_o   = '0;
        if (req) begin
            bus.add_o   = bus.add_i[int'(winner)*AddrWidth +: AddrWidth];
            bus.we_o    = bus.we_i[winner];
            bus.wdata_o = bus.wdata_i[int'(winner)*DataWidth +: DataWidth];
            bus.be_o    = bus.be_i[int'(winner)*BeWidth +: BeWidth];
        end
        if (hs) begin
            bus.gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        bus.vld_o    = '0;
        bus.rready_o = ~empty;
        bus.rdata_o  = {NumIn{bus.rdata_i}};
        bus.outst_o  = cnt_q;
        if (pop) begin
            bus.vld_o[fifo_q[rptr_q]] = 1'b1;
        end
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (lock_q && !bus.req_i[lock_idx_q]) begin
            lock_d = 1'b0;
        end
        if (hs) begin
            rr_d   = (winner == IdxW'(NumIn - 1)) ? '0 : winner + IdxW'(1);
            lock_d = 1'b0;
        end else if (req) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (hs) begin
            fifo_d[wptr_q] = winner;
            wptr_d = (wptr_q == PtrW'(NumOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(NumOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        unique case ({hs, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(NumOutstanding); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_varlat_bank_arbiter.sv
// Directed bench for varlat_bank_arbiter with a queue-based reference model.
module tb_varlat_bank_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NO = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    varlat_bank_arbiter_if #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW),
        .BeWidth(BW), .NumOutstanding(NO)
    ) bus ();

    varlat_bank_arbiter #(
        .NumIn(N), .AddrWidth(AW), .DataWidth(DW),
        .BeWidth(BW), .NumOutstanding(NO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level state
    int   m_fifo[$];
    int   m_rr;
    bit   m_lock;
    int   m_lidx;
    bit   m_valid = 0;

    always @(negedge clk) begin
        int w;
        int c;
        bit ereq;
        bit ehs;
        bit epop;
        logic [N-1:0] r;
        logic [N-1:0] egnt;
        logic [N-1:0] evld;
        logic [AW-1:0] eadd;
        logic ewe;
        logic [DW-1:0] ewd;
        logic [BW-1:0] ebe;
        r = bus.req_i;
        w = -1;
        if (m_lock && r[m_lidx]) begin
            w = m_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (w < 0 && r[c]) w = c;
            end
        end
        ereq = (r != 0) && (m_fifo.size() < NO);
        ehs  = ereq && bus.gnt_i;
        epop = bus.rvalid_i && (m_fifo.size() > 0);
        egnt = '0;
        evld = '0;
        eadd = '0;
        ewe  = 1'b0;
        ewd  = '0;
        ebe  = '0;
        if (ereq) begin
            eadd = bus.add_i[w*AW +: AW];
            ewe  = bus.we_i[w];
            ewd  = bus.wdata_i[w*DW +: DW];
            ebe  = bus.be_i[w*BW +: BW];
        end
        if (ehs) egnt[w] = 1'b1;
        if (epop) evld[m_fifo[0]] = 1'b1;
        if (m_valid) begin
            chk("m_req_o", 128'(bus.req_o), 128'(ereq));
            chk("m_gnt_o", 128'(bus.gnt_o), 128'(egnt));
            chk("m_add_o", 128'(bus.add_o), 128'(eadd));
            chk("m_we_o", 128'(bus.we_o), 128'(ewe));
            chk("m_wdata_o", 128'(bus.wdata_o), 128'(ewd));
            chk("m_be_o", 128'(bus.be_o), 128'(ebe));
            chk("m_vld_o", 128'(bus.vld_o), 128'(evld));
            chk("m_rready_o", 128'(bus.rready_o), 128'(m_fifo.size() > 0));
            chk("m_rdata_o", 128'(bus.rdata_o), 128'({N{bus.rdata_i}}));
            chk("m_outst_o", 128'(bus.outst_o), 128'(m_fifo.size()));
        end
        if (rst) begin
            m_fifo.delete();
            m_rr    = 0;
            m_lock  = 0;
            m_lidx  = 0;
            m_valid = 1;
        end else begin
            if (m_lock && !r[m_lidx]) m_lock = 0;
            if (epop) void'(m_fifo.pop_front());
            if (ehs) begin
                m_fifo.push_back(w);
                m_rr   = (w + 1) % N;
                m_lock = 0;
            end else if (ereq) begin
                m_lock = 1;
                m_lidx = w;
            end
        end
    end

    // Advance one cycle, apply inputs, settle at the falling edge.
    task automatic drv(input logic [N-1:0] rq, input logic g, input logic rv, input logic rs = 1'b0);
        @(posedge clk);
        #1;
        rst          = rs;
        bus.req_i    = rq;
        bus.gnt_i    = g;
        bus.rvalid_i = rv;
        bus.rdata_i  = 32'hA5A5_0000 + 32'($time);
        @(negedge clk);
    endtask

    int ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst          = 1'b1;
        bus.req_i    = '0;
        bus.gnt_i    = 1'b0;
        bus.rvalid_i = 1'b0;
        bus.rdata_i  = '0;
        bus.add_i    = {12'h103, 12'h102, 12'h005, 12'h100};
        bus.we_i     = 4'b1010;
        bus.wdata_i  = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        bus.be_i     = {4'hF, 4'h3, 4'hC, 4'h1};
        repeat (2) @(posedge clk);

        drv(4'b0000, 0, 0);
        chk("rst_req_o", 128'(bus.req_o), 0);
        chk("rst_gnt_o", 128'(bus.gnt_o), 0);
        chk("rst_vld_o", 128'(bus.vld_o), 0);
        chk("rst_rready", 128'(bus.rready_o), 0);
        chk("rst_outst", 128'(bus.outst_o), 0);

        drv(4'b0010, 1, 0);
        chk("t1_gnt", 128'(bus.gnt_o), 128'(4'b0010));
        chk("t1_add", 128'(bus.add_o), 128'(12'h005));
        drv(4'b0000, 0, 0);
        chk("t1_outst1", 128'(bus.outst_o), 1);
        chk("t1_rready", 128'(bus.rready_o), 1);
        drv(4'b0000, 0, 1);
        chk("t1_vld", 128'(bus.vld_o), 128'(4'b0010));
        drv(4'b0000, 0, 0);
        chk("t1_outst0", 128'(bus.outst_o), 0);

        drv(4'b0000, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drv(4'b1111, 1, 1);
            chk("t2_rr_gnt", 128'(bus.gnt_o), 128'(1 << ord[i]));
        end
        drv(4'b0000, 0, 1);
        chk("t2_drain_vld", 128'(bus.vld_o), 128'(4'b0001));

        drv(4'b0000, 0, 0, 1);
        drv(4'b1111, 0, 0);
        chk("t3_req_o", 128'(bus.req_o), 1);
        chk("t3_add_a", 128'(bus.add_o), 128'(12'h100));
        drv(4'b1111, 0, 0);
        chk("t3_gnt0", 128'(bus.gnt_o), 0);
        drv(4'b1011, 0, 0);
        chk("t3_add_b", 128'(bus.add_o), 128'(12'h100));
        drv(4'b1111, 1, 0);
        chk("t3_gnt", 128'(bus.gnt_o), 128'(4'b0001));
        drv(4'b1110, 1, 0);
        chk("t3_next", 128'(bus.gnt_o), 128'(4'b0010));
        drv(4'b0000, 0, 1);
        chk("t3_vld_a", 128'(bus.vld_o), 128'(4'b0001));
        drv(4'b0000, 0, 1);
        chk("t3_vld_b", 128'(bus.vld_o), 128'(4'b0010));
        drv(4'b0000, 0, 0);

        drv(4'b1111, 1, 0);
        chk("t4_gnt_a", 128'(bus.gnt_o), 128'(4'b0100));
        drv(4'b1011, 1, 0);
        chk("t4_gnt_b", 128'(bus.gnt_o), 128'(4'b1000));
        drv(4'b0011, 1, 0);
        chk("t4_full_req", 128'(bus.req_o), 0);
        chk("t4_full_gnt", 128'(bus.gnt_o), 0);
        chk("t4_full_outst", 128'(bus.outst_o), 2);
        drv(4'b0011, 1, 1);
        chk("t4_pop_vld", 128'(bus.vld_o), 128'(4'b0100));
        chk("t4_pop_req", 128'(bus.req_o), 0);
        drv(4'b0011, 1, 0);
        chk("t4_after_req", 128'(bus.req_o), 1);
        chk("t4_after_gnt", 128'(bus.gnt_o), 128'(4'b0001));
        drv(4'b0000, 0, 1);
        chk("t4_vld_c", 128'(bus.vld_o), 128'(4'b1000));
        drv(4'b0000, 0, 1);
        chk("t4_vld_d", 128'(bus.vld_o), 128'(4'b0001));
        drv(4'b0000, 0, 0);

        drv(4'b1000, 1, 0);
        chk("t5_gnt3", 128'(bus.gnt_o), 128'(4'b1000));
        drv(4'b0010, 1, 0);
        chk("t5_gnt1", 128'(bus.gnt_o), 128'(4'b0010));
        drv(4'b0000, 0, 1);
        chk("t5_vld3", 128'(bus.vld_o), 128'(4'b1000));
        drv(4'b0000, 0, 1);
        chk("t5_vld1", 128'(bus.vld_o), 128'(4'b0010));
        drv(4'b0000, 0, 1);
        chk("t5_spur_vld", 128'(bus.vld_o), 0);
        chk("t5_spur_rdy", 128'(bus.rready_o), 0);

        drv(4'b0001, 1, 0);
        drv(4'b0100, 1, 0);
        drv(4'b0000, 0, 0);
        chk("t6_outst2", 128'(bus.outst_o), 2);
        drv(4'b0000, 0, 0, 1);
        drv(4'b0000, 0, 1);
        chk("t6_outst0", 128'(bus.outst_o), 0);
        chk("t6_rready", 128'(bus.rready_o), 0);
        chk("t6_stale_vld", 128'(bus.vld_o), 0);
        drv(4'b1010, 1, 0);
        chk("t6_low_gnt", 128'(bus.gnt_o), 128'(4'b0010));

        drv(4'b0100, 0, 0);
        chk("unl_lock_req", 128'(bus.req_o), 1);
        drv(4'b1000, 1, 0);
        chk("unl_gnt", 128'(bus.gnt_o), 128'(4'b1000));
        drv(4'b0000, 0, 1);
        chk("unl_vld_a", 128'(bus.vld_o), 128'(4'b0010));
        drv(4'b0000, 0, 1);
        chk("unl_vld_b", 128'(bus.vld_o), 128'(4'b1000));
        drv(4'b0000, 0, 0);
        drv(4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
